// File: rtl/seq_cmd_rx_pkg.sv
`timescale 1ns/1ps
// Shared sequencer constants (mirrors seq_definitions) and ASCII helpers
// used by the UART command receiver.
package seq_cmd_rx_pkg;

  localparam int unsigned seq_in_width = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic logic is_eol(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

  // Nibble value of a hex character; only meaningful when is_hex(c).
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    logic [7:0] t;
    if (c <= 8'h39)      t = c - 8'h30;
    else if (c <= 8'h46) t = c - 8'h37;
    else                 t = c - 8'h57;
    return t[3:0];
  endfunction

endpackage

// File: rtl/seq_cmd_rx_fifo.sv
`timescale 1ns/1ps
// seq_cmd_fifo: small synchronous FIFO with first-word fall-through read
// data. A push while full is accepted only if a pop happens in the same cycle.
module seq_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]    rd_ptr_d, rd_ptr_q;
  logic [AW:0]      cnt_d, cnt_q;
  logic             do_wr, do_rd;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_cnt   = cnt_q;
  assign o_data  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_rd    = i_pop & ~o_empty;
    do_wr    = i_push & (~o_full | do_rd);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_cmd_rx.sv
`timescale 1ns/1ps
// seq_cmd_rx: parses ASCII hex command lines from the UART receiver into
// 8-bit sequencer instructions, buffers them, and issues them as paced
// single-cycle strobes while the UART transmitter is idle.
module seq_cmd_rx
  import seq_cmd_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ISSUE_GAP  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_tx_busy,
  output logic [seq_in_width-1:0]       o_inst,
  output logic                          o_inst_valid,
  output logic                          o_err,
  output logic [7:0]                    o_err_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  typedef enum logic [1:0] {
    S_HI  = 2'd0,
    S_LO  = 2'd1,
    S_EOL = 2'd2,
    S_ERR = 2'd3
  } state_e;

  localparam int unsigned GAP_W = (ISSUE_GAP < 1) ? 1 : $clog2(ISSUE_GAP + 1);

  logic [1:0]              rst_sync_d, rst_sync_q;
  logic                    rst_n;
  state_e                  state_d, state_q;
  logic [7:0]              byte_d, byte_q;
  logic [GAP_W-1:0]        gap_d, gap_q;
  logic [seq_in_width-1:0] inst_d, inst_q;
  logic                    inst_valid_d, inst_valid_q;
  logic                    err_d, err_q;
  logic [7:0]              err_cnt_d, err_cnt_q;
  logic                    commit, parse_err, pop;
  logic                    fifo_full, fifo_empty;
  logic [seq_in_width-1:0] fifo_rdata;

  // Reset asserts asynchronously and releases two clocks after rst rises.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  seq_cmd_fifo #(
    .WIDTH (seq_in_width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (commit),
    .i_data  (byte_q),
    .i_pop   (pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_cnt   (o_fifo_cnt)
  );

  // Line parser: advances only on received-byte strobes.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    commit    = 1'b0;
    parse_err = 1'b0;
    if (i_rx_valid) begin
      case (state_q)
        S_HI: begin
          if (is_hex(i_rx_data)) begin
            byte_d[7:4] = hex_nib(i_rx_data);
            state_d     = S_LO;
          end else if (!is_eol(i_rx_data) && (i_rx_data != ASCII_SP)) begin
            parse_err = 1'b1;
            state_d   = S_ERR;
          end
        end
        S_LO: begin
          if (is_hex(i_rx_data)) begin
            byte_d[3:0] = hex_nib(i_rx_data);
            state_d     = S_EOL;
          end else if (is_eol(i_rx_data)) begin
            parse_err = 1'b1;
            state_d   = S_HI;
          end else begin
            parse_err = 1'b1;
            state_d   = S_ERR;
          end
        end
        S_EOL: begin
          if (is_eol(i_rx_data)) begin
            commit  = 1'b1;
            state_d = S_HI;
          end else begin
            parse_err = 1'b1;
            state_d   = S_ERR;
          end
        end
        default: begin
          if (is_eol(i_rx_data)) state_d = S_HI;
        end
      endcase
    end
  end

  // Issue pacing, registered outputs and saturating error count.
  always_comb begin
    pop          = ~fifo_empty & ~i_tx_busy & (gap_q == '0);
    gap_d        = gap_q;
    if (pop)                gap_d = GAP_W'(ISSUE_GAP);
    else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);
    inst_d       = pop ? fifo_rdata : inst_q;
    inst_valid_d = pop;
    // Overflow: a commit into a full FIFO is only lost when nothing pops.
    err_d        = parse_err | (commit & fifo_full & ~pop);
    err_cnt_d    = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Block state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HI;
      byte_q       <= '0;
      gap_q        <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      gap_q        <= gap_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_inst       = inst_q;
  assign o_inst_valid = inst_valid_q;
  assign o_err        = err_q;
  assign o_err_cnt    = err_cnt_q;

endmodule
